// File: rtl/idct8_serial_stage.sv
// Serial 8-point 1-D inverse DCT stage: loads 8 coefficients, runs a 3-cycle
// Q8 butterfly pipeline with round-half-away and saturation, then streams 8 samples.
module idct8_serial_stage #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 9,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam int SW = IN_W + 12;
  localparam int SH = 9 + OUT_SHIFT;
  localparam logic signed [SW-1:0] C1 = SW'(251);
  localparam logic signed [SW-1:0] C2 = SW'(237);
  localparam logic signed [SW-1:0] C3 = SW'(213);
  localparam logic signed [SW-1:0] C4 = SW'(181);
  localparam logic signed [SW-1:0] C5 = SW'(142);
  localparam logic signed [SW-1:0] C6 = SW'(98);
  localparam logic signed [SW-1:0] C7 = SW'(50);
  localparam logic [SW:0] HALF    = (SW+1)'(1) << (SH - 1);
  localparam logic [SW:0] POS_MAX = (SW+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic [SW:0] NEG_MAG = (SW+1)'(1 << (OUT_W - 1));

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  ocnt_q, ocnt_d;
  logic [1:0]  ccnt_q, ccnt_d;
  logic        in_xfer, out_xfer;

  logic signed [IN_W-1:0]  coef_q [8];
  logic signed [SW-1:0]    fx     [8];
  logic signed [SW-1:0]    ev_d   [6];
  logic signed [SW-1:0]    ev_q   [6];
  logic signed [SW-1:0]    od_d   [4][4];
  logic signed [SW-1:0]    od_q   [4][4];
  logic signed [SW-1:0]    e      [4];
  logic signed [SW-1:0]    o      [4];
  logic signed [SW-1:0]    s_d    [8];
  logic signed [SW-1:0]    s_q    [8];
  logic signed [OUT_W-1:0] y_d    [8];
  logic signed [OUT_W-1:0] y_q    [8];

  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [SW-1:0] s);
    logic [SW-1:0] mag;
    logic [SW:0]   q;
    mag = s[SW-1] ? SW'(-s) : SW'(s);
    q   = ({1'b0, mag} + HALF) >> SH;
    if (!s[SW-1])
      round_sat = (q > POS_MAX) ? {1'b0, {(OUT_W-1){1'b1}}} : OUT_W'(q);
    else
      round_sat = (q > NEG_MAG) ? {1'b1, {(OUT_W-1){1'b0}}} : OUT_W'(-q);
  endfunction

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ocnt_d  = ocnt_q;
    ccnt_d  = ccnt_q;
    case (state_q)
      LOAD: if (in_xfer) begin
        cnt_d  = cnt_q + 3'd1;
        ccnt_d = '0;
        if (cnt_q == 3'd7) state_d = CALC;
      end
      CALC: begin
        ccnt_d = ccnt_q + 2'd1;
        if (ccnt_q == 2'd2) begin
          state_d = OUT;
          ccnt_d  = '0;
          ocnt_d  = '0;
        end
      end
      OUT: if (out_xfer) begin
        ocnt_d = ocnt_q + 3'd1;
        if (ocnt_q == 3'd7) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == OUT);
    out_last  = (state_q == OUT) && (ocnt_q == 3'd7);
    out_data  = (state_q == OUT) ? y_q[ocnt_q] : '0;
    busy      = !((state_q == LOAD) && (cnt_q == 3'd0));
  end

  // Stage 1 products, stage 2 even/odd butterfly, stage 3 rounding.
  always_comb begin
    for (int unsigned j = 0; j < 8; j++) fx[j] = SW'(coef_q[j]);
    ev_d[0] = C4 * (fx[0] + fx[4]);
    ev_d[1] = C4 * (fx[0] - fx[4]);
    ev_d[2] = C2 * fx[2];
    ev_d[3] = C6 * fx[2];
    ev_d[4] = C2 * fx[6];
    ev_d[5] = C6 * fx[6];
    for (int unsigned j = 0; j < 4; j++) begin
      od_d[j][0] = C1 * fx[2*j+1];
      od_d[j][1] = C3 * fx[2*j+1];
      od_d[j][2] = C5 * fx[2*j+1];
      od_d[j][3] = C7 * fx[2*j+1];
    end
    e[0] = ev_q[0] + ev_q[2] + ev_q[5];
    e[1] = ev_q[1] + ev_q[3] - ev_q[4];
    e[2] = ev_q[1] - ev_q[3] + ev_q[4];
    e[3] = ev_q[0] - ev_q[2] - ev_q[5];
    o[0] = od_q[0][0] + od_q[1][1] + od_q[2][2] + od_q[3][3];
    o[1] = od_q[0][1] - od_q[1][3] - od_q[2][0] - od_q[3][2];
    o[2] = od_q[0][2] - od_q[1][0] + od_q[2][3] + od_q[3][1];
    o[3] = od_q[0][3] - od_q[1][2] + od_q[2][1] - od_q[3][0];
    for (int unsigned x = 0; x < 4; x++) begin
      s_d[x]     = e[x] + o[x];
      s_d[7 - x] = e[x] - o[x];
    end
    for (int unsigned x = 0; x < 8; x++) y_d[x] = round_sat(s_q[x]);
  end

  always_ff @(posedge clk) begin
    if (in_xfer) coef_q[cnt_q] <= in_data;
    if (state_q == CALC) begin
      if (ccnt_q == 2'd0) begin
        ev_q <= ev_d;
        od_q <= od_d;
      end else if (ccnt_q == 2'd1) begin
        s_q <= s_d;
      end else begin
        y_q <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_idct8_serial_stage.sv
// Scoreboard bench for idct8_serial_stage with default parameters (row pass).
module tb_idct8_serial_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [11:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [8:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  idct8_serial_stage #(.IN_W(12), .OUT_W(9), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int data; bit last; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 0;
  int vec_beats = 0;
  int stall_cnt = 0;
  bit hold_pend = 0;
  int held_data;
  int held_last;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // cos(m*pi/16) in Q8, built from the first quadrant
  function automatic int cosq(input int m);
    int ctab[9];
    int mm;
    ctab = '{256, 251, 237, 213, 181, 142, 98, 50, 0};
    mm = m % 32;
    if (mm <= 8)       return  ctab[mm];
    else if (mm <= 16) return -ctab[16 - mm];
    else if (mm <= 24) return -ctab[mm - 16];
    else               return  ctab[32 - mm];
  endfunction

  function automatic int model(input int f[8], input int x);
    int s, mag, q, y;
    s = 181 * f[0];
    for (int u = 1; u < 8; u++) s += cosq((2*x + 1) * u) * f[u];
    mag = (s < 0) ? -s : s;
    q = (mag + 256) / 512;
    y = (s < 0) ? -q : q;
    if (y > 255) y = 255;
    if (y < -256) y = -256;
    return y;
  endfunction

  task automatic send_vec(input int f[8], input bit gaps);
    exp_t e;
    int t;
    for (int x = 0; x < 8; x++) begin
      e.data = model(f, x);
      e.last = (x == 7);
      exp_q.push_back(e);
    end
    for (int u = 0; u < 8; u++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 12'(f[u]);
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      check_eq("load_wait", int'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("calc_in_ready", int'(in_ready), 0);
    check_eq("calc_busy", int'(busy), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pend = 0;
    end else begin
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: if (out_valid && vec_beats == 2 && stall_cnt < 5) begin
             out_ready = 1'b0;
             stall_cnt++;
           end else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
      if (hold_pend) begin
        check_eq("hold_valid", int'(out_valid), 1);
        check_eq("hold_data", int'(out_data), held_data);
        check_eq("hold_last", int'(out_last), held_last);
      end
      hold_pend = 0;
      if (out_valid) begin
        check_eq("out_in_ready", int'(in_ready), 0);
        if (out_ready) begin
          check_eq("sb_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("out_data", int'(out_data), e.data);
            check_eq("out_last", int'(out_last), int'(e.last));
            if (e.last) begin
              vec_beats = 0;
              stall_cnt = 0;
            end else vec_beats++;
          end
        end else begin
          hold_pend = 1;
          held_data = int'(out_data);
          held_last = int'(out_last);
        end
      end
    end
  end

  initial begin
    int v[8];
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    #11 rst = 1'b0;
    @(negedge clk);

    v = '{64, 0, 0, 0, 0, 0, 0, 0};     send_vec(v, 0);
    v = '{-64, 0, 0, 0, 0, 0, 0, 0};    send_vec(v, 0);
    v = '{256, 0, 0, 0, 0, 0, 0, 0};    send_vec(v, 0);
    v = '{-256, 0, 0, 0, 0, 0, 0, 0};   send_vec(v, 0);
    v = '{0, 100, 0, 0, 0, 0, 0, 0};    send_vec(v, 0);
    v = '{2047, 0, 0, 0, 0, 0, 0, 0};   send_vec(v, 0);
    v = '{-2048, 0, 0, 0, 0, 0, 0, 0};  send_vec(v, 0);
    v = '{30, -20, 15, 40, -7, 3, 12, -9}; send_vec(v, 0);

    rdy_mode = 2;
    v = '{10, 55, -33, 7, 90, -14, 21, 60}; send_vec(v, 1);
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(0, 4095)) - 2048;
      send_vec(v, 1);
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(0, 200)) - 100;
      send_vec(v, 1);
    end
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_random", exp_q.size(), 0);

    rdy_mode = 0;
    v = '{0, 100, 0, 0, 0, 0, 0, 0};
    send_vec(v, 0);
    t = 0;
    while (vec_beats < 4 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("beat4_reached", vec_beats, 4);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", int'(out_valid), 0);
    check_eq("mid_rst_in_ready", int'(in_ready), 1);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_out_last", int'(out_last), 0);
    exp_q.delete();
    vec_beats = 0;
    stall_cnt = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    v = '{64, 0, 0, 0, 0, 0, 0, 0};
    send_vec(v, 0);
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_final", exp_q.size(), 0);
    @(negedge clk);
    check_eq("idle_in_ready", int'(in_ready), 1);
    check_eq("idle_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idct8_serial_stage.md
Name: idct8_serial_stage

Overview:
- Parametrised, sequential 8-point 1-D inverse DCT stage for the JPEG decoding path.
- Accepts one DCT coefficient per cycle over a valid/ready handshake and buffers a full vector of 8.
- Computes all 8 spatial samples with Q8 fixed-point constants, applies symmetric rounding and saturation, then streams the samples out with valid/ready/last.
- Used for both the row pass and the column pass; the two passes differ only in the parameters.

Parameters:
- IN_W, 12: signed input coefficient width.
- OUT_W, 9: signed output sample width.
- OUT_SHIFT, 0: extra right shift applied before rounding. Row pass uses 0; column pass uses 3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_W  signed coefficient F(u), sent in order u=0..7.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a coefficient this cycle.
- out_data  out  OUT_W  signed sample y(x), sent in order x=0..7.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts a sample this cycle.
- out_last  out  1  high with the y(7) beat.
- busy  out  1  high in any state other than LOAD with a zero count.

Behaviour:
- Reset (asynchronous, active-high, one clock):
  - Forces state LOAD and the load/output counters to 0.
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
  - Contents of the coefficient and result buffers are don't-care.
  - Reset asserted mid-vector or mid-output discards everything; no partial vector is ever emitted.
- Transfers:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- State LOAD:
  - in_ready=1.
  - Each input transfer writes coef[cnt] and increments cnt (3 bits).
  - The transfer with cnt=7 sets cnt to 0 and moves to CALC.
- State CALC (fixed 3 cycles, in_ready=0, out_valid=0):
  - Cycle 1 registers products.
  - Cycle 2 registers the even/odd butterfly sums S(x).
  - Cycle 3 registers the rounded and saturated y(0..7). The state then moves to OUT.
- Constants (Q8), c_k = round(256·cos(kπ/16)):
  - c1=251, c2=237, c3=213, c4=181, c5=142, c6=98, c7=50.
- Butterfly, computed in exact signed arithmetic (internal width ≥ IN_W+12, no overflow allowed):
  - Even part:
    - e0 = c4(F0+F4) + c2F2 + c6F6
    - e1 = c4(F0−F4) + c6F2 − c2F6
    - e2 = c4(F0−F4) − c6F2 + c2F6
    - e3 = c4(F0+F4) − c2F2 − c6F6
  - Odd part:
    - o0 = c1F1 + c3F3 + c5F5 + c7F7
    - o1 = c3F1 − c7F3 − c1F5 − c5F7
    - o2 = c5F1 − c1F3 + c7F5 + c3F7
    - o3 = c7F1 − c5F3 + c3F5 − c1F7
  - Outputs:
    - S(x) = e_x + o_x for x=0..3.
    - S(7−x) = e_x − o_x for x=0..3.
- Scaling and rounding:
  - D = 2^(9+OUT_SHIFT).
  - y = round-half-away-from-zero(S/D), i.e. sign(S)·floor((|S| + D/2)/D).
  - y is then saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Every one of the 8 outputs is computed; no lane is ever forced to zero.
- State OUT:
  - out_valid=1 and out_data = y(ocnt).
  - out_last=1 when ocnt=7.
  - On an output transfer ocnt increments. The transfer with ocnt=7 returns the block to LOAD.
  - With out_ready=0, out_data, out_valid and out_last hold stable.
  - in_ready=0 throughout, so no input is accepted until the vector drains.
- Throughput: minimum 19 cycles per vector (8 load + 3 calc + 8 out), with no bubbles inside the LOAD or OUT phases.
- Boundary conditions:
  - in_valid gaps inside LOAD simply stall the load count.
  - out_ready may toggle arbitrarily.
  - in_valid=1 while in_ready=0 has no effect.

Test Plan:
- DC: F0=64, rest 0, OUT_SHIFT=0 -> y(0..7)=23 each (181·64/512=22.625); F0=−64 -> all −23.
- Half-way rounding: F0=256 -> all 91 (exactly 90.5); F0=−256 -> all −91.
- Odd basis: F1=100 -> y = 49, 42, 28, 10, −10, −28, −42, −49; out_last only on the 8th beat.
- Saturation: F0=2047, OUT_W=9 -> all 255; F0=−2048 -> all −256.
- Handshake: random in_valid gaps plus out_ready low for 5 cycles on beat 3 -> out_data held stable, sequence unchanged, in_ready low from the 8th accepted input until the last output transfer.
- Reset mid-output after beat 4 -> out_valid drops asynchronously, in_ready=1; the next vector (F0=64) yields a clean 8-beat burst of 23.
